// File: rtl/bus_arb_pkg.sv
// rtl/bus_arb_pkg.sv - shared state encoding and constants for bus_arbiter
//
// Purpose: types and constants imported by the arbiter and its bench.
// Ports:   none (package).
// Optional feature macro: ARB_TIMEOUT_EN (the constants here are always present).

package bus_arb_pkg;

  // Arbiter phases: wait for a request, own the bus for one transaction,
  // then one dead cycle so a registered ready cannot leak into the next grant.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } arb_state_e;

  // Read data returned to a requester whose transaction timed out.
  localparam logic [31:0] ARB_ERR_DATA = 32'hDEAD_BEEF;

  // Default number of GRANT cycles without s_ready before aborting.
  localparam int ARB_TIMEOUT_DEFAULT = 255;

  // grant_id width: clog2 of the requester count, never narrower than 1 bit.
  function automatic int idw_for(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - requester-side and peripheral-side bus bundle for bus_arbiter
//
// Purpose: groups the per-requester request bus and the shared peripheral bus.
// Ports (signals):
//   m_addr/m_wdata [NREQ*32], m_wmask [NREQ*4], m_wen/m_ren [NREQ]  requests
//   m_rdata [32] broadcast read data, m_ready [NREQ] completion pulses
//   s_addr/s_wdata [32], s_wmask [4], s_wen/s_ren                  to peripheral
//   s_rdata [32], s_ready                                           from peripheral
// Modports:
//   slave  - the arbiter's view (serves requesters, drives the peripheral bus)
//   master - the surrounding system's view (requesters plus peripheral)

interface bus_arbiter_if #(
  parameter int NREQ = 2
);

  logic [NREQ*32-1:0] m_addr;
  logic [NREQ*32-1:0] m_wdata;
  logic [NREQ*4-1:0]  m_wmask;
  logic [NREQ-1:0]    m_wen;
  logic [NREQ-1:0]    m_ren;
  logic [31:0]        m_rdata;
  logic [NREQ-1:0]    m_ready;

  logic [31:0]        s_addr;
  logic [31:0]        s_wdata;
  logic [3:0]         s_wmask;
  logic               s_wen;
  logic               s_ren;
  logic [31:0]        s_rdata;
  logic               s_ready;

  modport slave (
    input  m_addr, m_wdata, m_wmask, m_wen, m_ren,
    output m_rdata, m_ready,
    output s_addr, s_wdata, s_wmask, s_wen, s_ren,
    input  s_rdata, s_ready
  );

  modport master (
    output m_addr, m_wdata, m_wmask, m_wen, m_ren,
    input  m_rdata, m_ready,
    input  s_addr, s_wdata, s_wmask, s_wen, s_ren,
    output s_rdata, s_ready
  );

endinterface

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin requester selection
//
// Purpose: choose the first requesting index after the last served one.
// Ports:
//   req_i  [NREQ] in   request vector
//   last_i [IDW]  in   index served most recently
//   any_o         out  at least one request present
//   idx_o  [IDW]  out  chosen index (searching last+1, last+2, ... mod NREQ)

module rr_picker #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  last_i,
  output logic            any_o,
  output logic [IDW-1:0]  idx_o
);

  function automatic logic [IDW-1:0] slot(input logic [IDW-1:0] base, input int k);
    return IDW'((int'(base) + k) % NREQ);
  endfunction

  assign any_o = |req_i;

  // Walk from the farthest candidate to the nearest so the nearest
  // requesting slot after last_i is the final (winning) assignment.
  always_comb begin
    idx_o = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req_i[slot(last_i, k)]) begin
        idx_o = slot(last_i, k);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin arbiter sharing one peripheral bus between NREQ requesters
//
// Purpose: grants the peripheral bus to one requester per transaction, with a
//          mandatory turnaround cycle after each completion.
// Ports:
//   clk            in   clock, all state on the rising edge
//   rst            in   asynchronous active-high reset
//   bus            -    bus_arbiter_if.slave (requester and peripheral buses)
//   busy           out  high in GRANT or TURN
//   grant_id [IDW] out  current / last granted requester
//   err            out  timeout pulse, coincident with m_ready (ARB_TIMEOUT_EN only)
// Optional feature macro: ARB_TIMEOUT_EN enables the GRANT wait counter,
//   the TIMEOUT abort and the err port. Without it GRANT waits indefinitely.

module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int IDW     = idw_for(NREQ),
  parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  bus_arbiter_if.slave   bus,
  output logic           busy,
  output logic [IDW-1:0] grant_id
`ifdef ARB_TIMEOUT_EN
  ,
  output logic           err
`endif
);

  arb_state_e     state_q;
  logic [IDW-1:0] grant_q;
  logic [IDW-1:0] last_q;
  logic           busy_q;

  logic [NREQ-1:0] req;
  logic            pick_any;
  logic [IDW-1:0]  pick_idx;

  assign req = bus.m_wen | bus.m_ren;

  rr_picker #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_picker (
    .req_i  (req),
    .last_i (last_q),
    .any_o  (pick_any),
    .idx_o  (pick_idx)
  );

  // Slice of the granted requester.
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_wmask;
  logic        sel_wen;
  logic        sel_ren;

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wmask = '0;
    sel_wen   = 1'b0;
    sel_ren   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q == IDW'(i)) begin
        sel_addr  = bus.m_addr[32*i +: 32];
        sel_wdata = bus.m_wdata[32*i +: 32];
        sel_wmask = bus.m_wmask[4*i +: 4];
        sel_wen   = bus.m_wen[i];
        sel_ren   = bus.m_ren[i];
      end
    end
  end

  logic in_grant;
  logic done_ok;
  logic tmo_hit;
  logic complete;

  assign in_grant = (state_q == GRANT);
  // s_ready is only meaningful in GRANT; in TURN it is the stale registered
  // ready of the transaction just finished and must be ignored.
  assign done_ok  = in_grant && bus.s_ready;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CW-1:0] cnt_q;

  // A real ready in the same cycle takes precedence over the abort.
  assign tmo_hit = in_grant && !bus.s_ready && (cnt_q == CW'(TIMEOUT));
  assign err     = tmo_hit;
`else
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT == 0);
  assign tmo_hit        = 1'b0;
`endif

  assign complete = done_ok || tmo_hit;

  // Peripheral bus is driven only while granted; a read is dropped when the
  // requester raises both enables, so the write wins.
  assign bus.s_addr  = in_grant ? sel_addr  : 32'h0;
  assign bus.s_wdata = in_grant ? sel_wdata : 32'h0;
  assign bus.s_wmask = in_grant ? sel_wmask : 4'h0;
  assign bus.s_wen   = in_grant && sel_wen;
  assign bus.s_ren   = in_grant && sel_ren && !sel_wen;

  always_comb begin
    bus.m_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      bus.m_ready[i] = complete && (grant_q == IDW'(i));
    end
  end

  assign bus.m_rdata = done_ok ? bus.s_rdata :
                       tmo_hit ? ARB_ERR_DATA : 32'h0;

  assign busy     = busy_q;
  assign grant_id = grant_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      // Pointing at the last slot makes requester 0 the first choice.
      last_q  <= IDW'(NREQ - 1);
      busy_q  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            grant_q <= pick_idx;
            state_q <= GRANT;
            busy_q  <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end
        GRANT: begin
          if (complete) begin
            last_q  <= grant_q;
            state_q <= TURN;
          end
`ifdef ARB_TIMEOUT_EN
          else begin
            cnt_q <= cnt_q + CW'(1);
          end
`endif
        end
        TURN: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - self-checking bench for bus_arbiter (directed + randomized)

module tb_bus_arbiter;
  import bus_arb_pkg::*;

  localparam int NREQ = 2;
  localparam int IDW  = 1;
`ifdef ARB_TIMEOUT_EN
  localparam int TMO = 10;
`else
  localparam int TMO = 255;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           busy;
  logic [IDW-1:0] grant_id;
  logic           err;

  always #5 clk = ~clk;

  bus_arbiter_if #(.NREQ(NREQ)) bus ();

  bus_arbiter #(
    .NREQ    (NREQ),
    .IDW     (IDW),
    .TIMEOUT (TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .grant_id (grant_id)
`ifdef ARB_TIMEOUT_EN
    ,
    .err      (err)
`endif
  );

`ifndef ARB_TIMEOUT_EN
  assign err = 1'b0;
`endif

  typedef struct {
    logic        v;
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } txn_t;

  txn_t pend [NREQ];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // transaction-level reference
  bit active;
  int exp_id, exp_start, last_srv, gid, turn_cyc, next_arb, ncomp;
  int served[$];

  // environment knobs and peripheral state
  int          req_pct, lat_max, stale_mode, ph, remain;
  bit          stall, use_fix;
  logic [31:0] fix_val;
  logic        rdy_next, cur_rdy;
  logic [31:0] rdata_next, cur_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h cyc=%0d", tag, obs, exp, cyc);
    end
  endtask

  function automatic txn_t new_txn();
    txn_t t;
    int   kind;
    kind    = int'($urandom_range(1, 3));
    t.v     = 1'b1;
    t.we    = kind[0];
    t.re    = kind[1];
    t.addr  = $urandom;
    t.wdata = $urandom;
    t.wmask = 4'($urandom_range(0, 15));
    return t;
  endfunction

  // Round robin from the rules: first pending requester after the last served.
  function automatic int rr_next(input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (pend[(last + k) % NREQ].v) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      bus.m_addr[32*i +: 32]  = pend[i].v ? pend[i].addr : $urandom;
      bus.m_wdata[32*i +: 32] = pend[i].v ? pend[i].wdata : $urandom;
      bus.m_wmask[4*i +: 4]   = pend[i].v ? pend[i].wmask : 4'h0;
      bus.m_wen[i]            = pend[i].v && pend[i].we;
      bus.m_ren[i]            = pend[i].v && pend[i].re;
    end
  endtask

  task automatic check_cycle();
    bit          in_g, done, tmo;
    txn_t        p;
    logic [31:0] mr_exp, rd_exp;
    in_g = active && (cyc >= exp_start);
    done = in_g && cur_rdy;
`ifdef ARB_TIMEOUT_EN
    tmo  = in_g && !cur_rdy && ((cyc - exp_start) == TMO);
`else
    tmo  = 1'b0;
`endif
    p = '{default: '0};
    if (in_g) p = pend[exp_id];
    mr_exp = (done || tmo) ? (32'd1 << exp_id) : 32'd0;
    rd_exp = done ? cur_rdata : (tmo ? 32'hDEAD_BEEF : 32'd0);
    chk("m_ready", 32'(bus.m_ready), mr_exp);
    chk("m_rdata", bus.m_rdata, rd_exp);
    chk("s_wen", 32'(bus.s_wen), 32'(in_g && p.we));
    chk("s_ren", 32'(bus.s_ren), 32'(in_g && p.re && !p.we));
    chk("s_addr", bus.s_addr, in_g ? p.addr : 32'd0);
    chk("s_wdata", bus.s_wdata, in_g ? p.wdata : 32'd0);
    chk("s_wmask", 32'(bus.s_wmask), in_g ? 32'(p.wmask) : 32'd0);
    chk("busy", 32'(busy), 32'(in_g || (cyc == turn_cyc)));
    chk("grant_id", 32'(grant_id), 32'(gid));
`ifdef ARB_TIMEOUT_EN
    chk("err", 32'(err), 32'(tmo));
`endif
    for (int i = 0; i < NREQ; i++) begin
      if (bus.m_ready[i] === 1'b1) begin
        served.push_back(i);
        break;
      end
    end
    if (done || tmo) begin
      active       = 1'b0;
      last_srv     = exp_id;
      turn_cyc     = cyc + 1;
      next_arb     = cyc + 2;
      pend[exp_id].v = 1'b0;
      ncomp++;
    end else if (!active && (cyc >= next_arb)) begin
      int n;
      n = rr_next(last_srv);
      if (n >= 0) begin
        active    = 1'b1;
        exp_id    = n;
        exp_start = cyc + 1;
        gid       = n;
      end
    end
  endtask

  // Peripheral with a registered ready: decides at the negedge what ready
  // looks like during the next cycle.
  task automatic periph();
    bit req_seen;
    req_seen = (bus.s_wen === 1'b1) || (bus.s_ren === 1'b1);
    if (stall) begin
      rdy_next = 1'b0;
      ph       = 0;
    end else if (ph == 2) begin
      if (stale_mode == 1 || (stale_mode == 2 && $urandom_range(0, 1) == 1)) begin
        rdy_next   = 1'b1;
        rdata_next = $urandom;
        ph         = 3;
      end else begin
        rdy_next = 1'b0;
        ph       = 0;
      end
    end else if (ph == 3) begin
      rdy_next = 1'b0;
      ph       = 0;
    end else begin
      rdy_next = 1'b0;
      if (ph == 0 && req_seen) begin
        remain = int'($urandom_range(0, lat_max));
        ph     = 1;
      end
      if (ph == 1) begin
        if (remain == 0) begin
          rdy_next   = 1'b1;
          rdata_next = use_fix ? fix_val : $urandom;
          ph         = 2;
        end else begin
          remain--;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (!pend[i].v && req_pct > 0 && int'($urandom_range(0, 99)) < req_pct) pend[i] = new_txn();
    end
    drive();
    cur_rdy     = rdy_next;
    cur_rdata   = rdata_next;
    bus.s_ready = cur_rdy;
    bus.s_rdata = cur_rdata;
    cyc++;
    @(negedge clk);
    check_cycle();
    periph();
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    active   = 1'b0;
    last_srv = NREQ - 1;
    gid      = 0;
    turn_cyc = -10;
    next_arb = 0;
    for (int i = 0; i < NREQ; i++) pend[i] = '{default: '0};
    drive();
    rdy_next    = 1'b0;
    rdata_next  = 32'd0;
    cur_rdy     = 1'b0;
    cur_rdata   = 32'd0;
    bus.s_ready = 1'b0;
    bus.s_rdata = 32'hFFFF_FFFF;
    ph          = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_s_wen", 32'(bus.s_wen), 32'd0);
    chk("rst_s_ren", 32'(bus.s_ren), 32'd0);
    chk("rst_s_addr", bus.s_addr, 32'd0);
    chk("rst_m_ready", 32'(bus.m_ready), 32'd0);
    chk("rst_m_rdata", bus.m_rdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic drain();
    int n;
    bit left;
    req_pct = 0;
    n = 0;
    left = 1'b1;
    while (left && n < 60) begin
      step();
      n++;
      left = active;
      for (int i = 0; i < NREQ; i++) left = left || pend[i].v;
    end
    chk("drain", 32'(left), 32'd0);
  endtask

  initial begin
    int seq[4];
    int base;
    req_pct    = 0;
    lat_max    = 0;
    stale_mode = 0;
    stall      = 1'b0;
    use_fix    = 1'b0;
    fix_val    = 32'd0;
    ncomp      = 0;
    rst        = 1'b1;

    // reset state
    do_reset();

    // single read from requester 1
    served.delete();
    use_fix = 1'b1;
    fix_val = 32'h0000_1234;
    pend[1] = '{v: 1'b1, we: 1'b0, re: 1'b1, addr: 32'h0000_F000, wdata: 32'h0, wmask: 4'h0};
    step();
    step();
    chk("rd_s_ren_c1", 32'(bus.s_ren), 32'd1);
    chk("rd_s_addr_c1", bus.s_addr, 32'h0000_F000);
    step();
    chk("rd_m_ready_c2", 32'(bus.m_ready), 32'b10);
    chk("rd_m_rdata_c2", bus.m_rdata, 32'h0000_1234);
    step();
    chk("rd_busy_c3", 32'(busy), 32'd1);
    chk("rd_m_ready_c3", 32'(bus.m_ready), 32'd0);
    step();
    chk("rd_busy_c4", 32'(busy), 32'd0);
    chk("rd_served_n", 32'(served.size()), 32'd1);
    use_fix = 1'b0;

    // write wins over read
    pend[0] = '{v: 1'b1, we: 1'b1, re: 1'b1, addr: 32'h0000_0040, wdata: 32'hA5A5_5A5A, wmask: 4'b0101};
    step();
    step();
    chk("ww_s_wen", 32'(bus.s_wen), 32'd1);
    chk("ww_s_ren", 32'(bus.s_ren), 32'd0);
    chk("ww_s_wmask", 32'(bus.s_wmask), 32'b0101);
    drain();

    // simultaneous writes from reset, continuous traffic alternates
    do_reset();
    served.delete();
    seq = '{0, 1, 0, 1};
    pend[0] = new_txn();
    pend[0].we = 1'b1;
    pend[1] = new_txn();
    pend[1].we = 1'b1;
    req_pct = 100;
    repeat (16) step();
    chk("alt_n", 32'(served.size() >= 4), 32'd1);
    for (int i = 0; i < 4; i++) chk("alt_order", 32'(served[i]), 32'(seq[i]));

    // stale ready held into TURN must not produce extra pulses
    stale_mode = 1;
    base = served.size();
    repeat (16) step();
    chk("stale_n", 32'(served.size() - base), 32'd4);
    for (int i = base + 1; i < served.size(); i++)
      chk("stale_alt", 32'(served[i] != served[i-1]), 32'd1);
    drain();
    stale_mode = 0;

    // reset while granted and stalled
    stall   = 1'b1;
    pend[1] = new_txn();
    step();
    step();
    step();
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_grant", 32'(grant_id), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_s_wen", 32'(bus.s_wen), 32'd0);
    chk("async_s_ren", 32'(bus.s_ren), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_grant", 32'(grant_id), 32'd0);
    chk("async_m_ready", 32'(bus.m_ready), 32'd0);
    do_reset();
    stall = 1'b0;
    served.delete();
    pend[0] = new_txn();
    pend[1] = new_txn();
    repeat (10) step();
    chk("post_rst_n", 32'(served.size()), 32'd2);
    chk("post_rst_first", 32'(served[0]), 32'd0);
    drain();

    // slave never ready
    stall = 1'b1;
    served.delete();
    pend[0] = new_txn();
    pend[0].we = 1'b1;
`ifdef ARB_TIMEOUT_EN
    begin
      int n;
      bit seen;
      n = 0;
      seen = 1'b0;
      while (!seen && n < 40) begin
        step();
        n++;
        if (bus.m_ready[0] === 1'b1) begin
          seen = 1'b1;
          chk("tmo_err", 32'(err), 32'd1);
          chk("tmo_rdata", bus.m_rdata, 32'hDEAD_BEEF);
        end
      end
      chk("tmo_seen", 32'(seen), 32'd1);
      chk("tmo_latency", 32'(n), 32'(TMO + 2));
    end
    stall = 1'b0;
    drain();
`else
    repeat (1000) step();
    chk("wait_no_ready", 32'(served.size()), 32'd0);
    chk("wait_busy", 32'(busy), 32'd1);
    chk("wait_s_wen", 32'(bus.s_wen), 32'd1);
    stall = 1'b0;
    drain();
    chk("wait_done", 32'(served.size()), 32'd1);
`endif

    // randomized traffic against the reference
    do_reset();
    served.delete();
    ncomp      = 0;
    lat_max    = 2;
    stale_mode = 2;
    req_pct    = 30;
    repeat (3000) step();
    drain();
    chk("rand_count", 32'(served.size()), 32'(ncomp));
    chk("rand_activity", 32'(ncomp > 100), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
